// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type and parameter defaults for the instruction-fetch stage
package fetch_pkg;

  localparam int PC_W_DEF     = 12;
  localparam int INSTR_W_DEF  = 32;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// rtl/fetch_prefetch_buf.sv - one-entry prefetch buffer with request-pending and data-valid flags
module fetch_prefetch_buf
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               ack,
  input  logic [PC_W-1:0]    addr,
  input  logic               cap,
  input  logic               clr,
  input  logic [INSTR_W-1:0] rdata,
  output logic               full,
  output logic [INSTR_W-1:0] data,
  output logic [PC_W-1:0]    req_addr
);

  logic               pend_q, pend_d;
  logic               full_q, full_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [PC_W-1:0]    addr_q, addr_d;

  always_comb begin
    pend_d = req && !ack;
    // Latch the address only on the cycle a request first rises; it must not move until ack.
    addr_d = (req && !pend_q) ? addr : addr_q;
    full_d = full_q;
    data_d = data_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (cap) begin
      full_d = 1'b1;
      data_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      full_q <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      pend_q <= pend_d;
      full_q <= full_d;
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end

  assign full     = full_q;
  assign data     = data_q;
  assign req_addr = addr_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction fetch over req/ack memory and valid/ready decode
// Define FETCH_PREFETCH_EN to add the pc+1 prefetch buffer and DRAIN state.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    next_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               id_ready
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               if_valid_q, if_valid_d;
  logic               accept;

  assign accept = if_valid_q && id_ready;

`ifdef FETCH_PREFETCH_EN
  logic [PC_W-1:0]    seq_pc;
  logic [PC_W-1:0]    drain_addr;
  logic [INSTR_W-1:0] buf_data;
  logic               buf_full;
  logic               buf_cap;

  assign seq_pc  = pc_q + PC_W'(1);
  assign buf_cap = (state_q == HOLD) && imem_req && imem_ack && !accept;

  fetch_prefetch_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_prefetch_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (imem_req),
    .ack      (imem_ack),
    .addr     (imem_addr),
    .cap      (buf_cap),
    .clr      (accept),
    .rdata    (imem_rdata),
    .full     (buf_full),
    .data     (buf_data),
    .req_addr (drain_addr)
  );
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
`ifdef FETCH_PREFETCH_EN
        imem_req  = !buf_full;
        imem_addr = seq_pc;
`endif
        if (accept) begin
          pc_d       = next_pc;
          if_valid_d = 1'b0;
          state_d    = FETCH;
`ifdef FETCH_PREFETCH_EN
          // A pending pc+1 read carries straight into FETCH with its address unchanged.
          if (next_pc == seq_pc) begin
            if (buf_full) begin
              if_instr_d = buf_data;
              if_pc_d    = seq_pc;
              if_valid_d = 1'b1;
              state_d    = HOLD;
            end else if (imem_ack) begin
              if_instr_d = imem_rdata;
              if_pc_d    = seq_pc;
              if_valid_d = 1'b1;
              state_d    = HOLD;
            end
          end else if (!buf_full && !imem_ack) begin
            state_d = DRAIN;
          end
`endif
        end
      end
`ifdef FETCH_PREFETCH_EN
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        if (imem_ack) state_d = FETCH;
      end
`endif
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign pc       = pc_q;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit against an instruction-stream model
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pc, next_pc, imem_addr, if_pc;
  logic        imem_req, imem_ack, if_valid, id_ready;
  logic [31:0] imem_rdata, if_instr;

  logic [11:0] w_pc, w_next_pc, w_imem_addr, w_if_pc;
  logic        w_imem_req, w_imem_ack, w_if_valid, w_id_ready;
  logic [31:0] w_imem_rdata, w_if_instr;

  int   mem_wait;
  logic force_ack;
  int   wcnt;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [11:0] a);
    return {~a, 8'h5A, a};
  endfunction

  // Memory: acks once a request has waited mem_wait cycles (0 = same cycle).
  assign imem_ack   = force_ack || (imem_req && (wcnt >= mem_wait));
  assign imem_rdata = mem_fn(imem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign w_imem_ack   = w_imem_req;
  assign w_imem_rdata = mem_fn(w_imem_addr);
  assign w_id_ready   = 1'b1;
  assign w_next_pc    = w_pc + 12'd1;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );

  pc_fetch_unit #(.RESET_PC(12'hFFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc(w_pc), .next_pc(w_next_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
    .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .id_ready(w_id_ready)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int wait_cycles);
    rst_n = 1'b0;
    force_ack = 1'b0;
    id_ready = 1'b0;
    next_pc = 12'h000;
    mem_wait = wait_cycles;
    repeat (2) step;
    rst_n = 1'b1;
  endtask

  // Model: the k-th instruction delivered must be at the address chosen at the (k-1)-th accept.
  task automatic run_stream(input int n, input logic [11:0] start_pc, input int jump_pct,
                            input int stall_len, input int exp_int, input string tag);
    logic [11:0] m_pc, prev_addr, prev_ifpc;
    logic [31:0] prev_instr;
    int delivered, cyc, last_acc, stall_left;
    bit want_new, prev_req, prev_ack, prev_valid, prev_ready;
    m_pc = start_pc;
    delivered = 0; cyc = 0; last_acc = -1; stall_left = 0;
    want_new = 1; prev_req = 0; prev_ack = 0; prev_valid = 0; prev_ready = 1;
    prev_addr = '0; prev_ifpc = '0; prev_instr = '0;
    while (delivered < n && cyc < 3000) begin
      if (prev_req && !prev_ack) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL %s_req_stable: req=%b addr=%h, required req=1 addr=%h", tag, imem_req, imem_addr, prev_addr);
        end
      end
      if (prev_valid && !prev_ready) begin
        checks++;
        if (if_valid !== 1'b1 || if_instr !== prev_instr || if_pc !== prev_ifpc) begin
          errors++;
          $display("FAIL %s_stall_stable: valid=%b instr=%h pc=%h, required 1 %h %h", tag, if_valid, if_instr, if_pc, prev_instr, prev_ifpc);
        end
      end
`ifndef FETCH_PREFETCH_EN
      if (if_valid) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL %s_hold_no_req: req=%b while valid, required 0", tag, imem_req);
        end
      end
`endif
      if (if_valid && want_new) begin
        checks++;
        if (if_pc !== m_pc || if_instr !== mem_fn(m_pc) || pc !== m_pc) begin
          errors++;
          $display("FAIL %s_instr: if_pc=%h instr=%h pc=%h, required %h %h %h", tag, if_pc, if_instr, pc, m_pc, mem_fn(m_pc), m_pc);
        end
        want_new = 0;
        stall_left = (stall_len < 0) ? int'($urandom_range(0, 4)) : stall_len;
      end
      if (!if_valid) id_ready = 1'($urandom_range(0, 1));
      else if (stall_left > 0) begin
        id_ready = 1'b0;
        stall_left--;
      end else id_ready = 1'b1;
      next_pc = 12'($urandom);
      if (if_valid && id_ready) begin
        if (int'($urandom_range(0, 99)) < jump_pct) next_pc = 12'($urandom);
        else next_pc = m_pc + 12'd1;
        if (exp_int > 0 && last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != exp_int) begin
            errors++;
            $display("FAIL %s_interval: %0d cycles between accepts, required %0d", tag, cyc - last_acc, exp_int);
          end
        end
        last_acc = cyc;
        m_pc = next_pc;
        delivered++;
        want_new = 1;
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      prev_valid = if_valid; prev_ready = id_ready; prev_instr = if_instr; prev_ifpc = if_pc;
      if (delivered < n) step;
      cyc++;
    end
    checks++;
    if (delivered != n) begin
      errors++;
      $display("FAIL %s_timeout: delivered %0d, required %0d", tag, delivered, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; force_ack = 1'b1; id_ready = 1'b1; next_pc = 12'h555; mem_wait = 0;
    repeat (3) step;
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h required 000", pc); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b required 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h required 0", if_instr); end
    checks++; if (if_pc !== 12'h000) begin errors++; $display("FAIL reset_if_pc: got %h required 000", if_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b required 0", imem_req); end
    checks++; if (imem_addr !== 12'h000) begin errors++; $display("FAIL reset_imem_addr: got %h required 000", imem_addr); end
    force_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_no_req: got %b required 0", imem_req); end
    step;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
      errors++; $display("FAIL first_req: req=%b addr=%h required 1 000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential;
    do_reset(0);
`ifdef FETCH_PREFETCH_EN
    run_stream(6, 12'h000, 0, 0, 1, "seq");
`else
    run_stream(6, 12'h000, 0, 0, 2, "seq");
`endif
  endtask

  task automatic test_jump;
    logic [11:0] exp_addr;
    do_reset(2);
    for (int i = 0; i < 20 && !if_valid; i++) step;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 12'h000) begin
      errors++; $display("FAIL jump_first: valid=%b if_pc=%h required 1 000", if_valid, if_pc);
    end
    id_ready = 1'b1;
    next_pc = 12'h222;
    step;
`ifdef FETCH_PREFETCH_EN
    exp_addr = 12'h001;
`else
    exp_addr = 12'h222;
`endif
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      errors++; $display("FAIL jump_addr: req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_addr);
    end
    next_pc = 12'h000;
    for (int i = 0; i < 20 && !if_valid; i++) step;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 12'h222 || if_instr !== mem_fn(12'h222)) begin
      errors++; $display("FAIL jump_target: valid=%b if_pc=%h instr=%h required 1 222 %h", if_valid, if_pc, if_instr, mem_fn(12'h222));
    end
  endtask

  task automatic test_stall;
    do_reset(3);
`ifdef FETCH_PREFETCH_EN
    run_stream(8, 12'h000, 25, 4, 0, "stall");
`else
    run_stream(8, 12'h000, 25, 4, 9, "stall");
`endif
  endtask

  task automatic test_jumps;
    do_reset(0);
`ifdef FETCH_PREFETCH_EN
    run_stream(16, 12'h000, 50, 0, 0, "jumps");
`else
    run_stream(16, 12'h000, 50, 0, 2, "jumps");
`endif
  endtask

  task automatic test_wrap;
    logic [11:0] got[$];
    logic [11:0] exp_pc;
    rst_n = 1'b0;
    step;
    checks++;
    if (w_imem_req !== 1'b0 || w_imem_addr !== 12'hFFE || w_pc !== 12'hFFE) begin
      errors++; $display("FAIL wrap_reset: req=%b addr=%h pc=%h required 0 ffe ffe", w_imem_req, w_imem_addr, w_pc);
    end
    rst_n = 1'b1;
    step;
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 12'hFFE) begin
      errors++; $display("FAIL wrap_first_req: req=%b addr=%h required 1 ffe", w_imem_req, w_imem_addr);
    end
    for (int i = 0; i < 20 && got.size() < 4; i++) begin
      if (w_if_valid) begin
        got.push_back(w_if_pc);
        checks++;
        if (w_if_instr !== mem_fn(w_if_pc)) begin
          errors++; $display("FAIL wrap_instr: got %h required %h", w_if_instr, mem_fn(w_if_pc));
        end
      end
      step;
    end
    exp_pc = 12'hFFE;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size()) begin
        errors++; $display("FAIL wrap_seq%0d: missing, required %h", i, exp_pc);
      end else if (got[i] !== exp_pc) begin
        errors++; $display("FAIL wrap_seq%0d: got %h required %h", i, got[i], exp_pc);
      end
      exp_pc = exp_pc + 12'd1;
    end
  endtask

  task automatic test_reset_mid;
    do_reset(0);
    run_stream(2, 12'h000, 0, 0, 0, "mid_pre");
    mem_wait = 5;
    step;
    checks++;
    if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin
      errors++; $display("FAIL mid_req_open: req=%b ack=%b required 1 0", imem_req, imem_ack);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 12'h000 || pc !== 12'h000 || if_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: req=%b addr=%h pc=%h valid=%b required 0 000 000 0", imem_req, imem_addr, pc, if_valid);
    end
    step;
    rst_n = 1'b1;
    mem_wait = 0;
    run_stream(3, 12'h000, 0, 0, 0, "mid_post");
  endtask

  task automatic test_random;
    do_reset(int'($urandom_range(0, 3)));
    run_stream(30, 12'h000, 30, -1, 0, "rand");
  endtask

  initial begin
    rst_n = 1'b0; force_ack = 1'b0; id_ready = 1'b0; next_pc = 12'h000; mem_wait = 0;
    test_reset;
    test_sequential;
    test_jump;
    test_stall;
    test_jumps;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage holding the architectural PC register. Presents `pc` to the combinational next-PC logic and samples its `next_pc` result. Issues word reads to instruction memory over a req/ack handshake and delivers each fetched instruction to decode over a valid/ready handshake. An optional sequential prefetch reaches one instruction per cycle on straight-line code.

## Interface
- `RESET_PC`, 12'h000, PC value loaded at reset (word address)
- `PC_W`, 12, PC/address width
- `INSTR_W`, 32, instruction width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `pc` out PC_W: current PC, drives next-PC logic
- `next_pc` in PC_W: next PC from next-PC logic, sampled on decode accept
- `imem_req` out 1: instruction-memory read request
- `imem_addr` out PC_W: read word address
- `imem_ack` in 1: read complete; `imem_rdata` valid this cycle
- `imem_rdata` in INSTR_W: read data
- `if_valid` out 1: `if_instr`/`if_pc` valid for decode
- `if_instr` out INSTR_W: fetched instruction
- `if_pc` out PC_W: address of `if_instr`
- `id_ready` in 1: decode accepts when `if_valid && id_ready`

## Operation
- Reset values: `pc`=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0, `imem_req`=0, `imem_addr`=RESET_PC, state BOOT, prefetch buffer empty.
- States: BOOT → FETCH unconditionally on the first edge after reset release.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`: `if_instr`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1, go HOLD.
- HOLD: `if_valid`=1; outputs stable while `id_ready`=0.
  - On accept: `pc`<=`next_pc`, `if_valid`<=0, go FETCH (base behaviour).
- DRAIN (prefetch only): `imem_req` held on the stale address until ack; data discarded; then FETCH.
- Handshake rule: once `imem_req` rises, `imem_req` and `imem_addr` stay stable until the cycle `imem_ack`=1 inclusive. Ack may arrive in the same cycle as req (zero-wait). `imem_ack` without `imem_req` is ignored.
- Arithmetic: sequential address `pc+1` is modulo 2^PC_W; 12'hFFF wraps to 12'h000.
- `next_pc` is treated as don't-care except on the accept edge.
- `rst_n` low mid-transfer: all state returns to reset values immediately. An outstanding request is abandoned; the memory side must tolerate this.

## Timing
- Zero-wait memory, base: req cycle N, `if_valid` at N+1, accept at N+1, next req at N+2. Throughput is 1 instruction / 2 cycles.
- Each memory wait cycle adds one cycle.
- Decode stall adds exactly the stall cycles; no request is issued while in HOLD (base).
- `pc` changes only on the accept edge; `if_pc` changes only on the ack-capture edge.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - In HOLD, issue a request for `pc+1` into a one-entry buffer.
  - On accept with `next_pc == pc+1`:
    - Buffered data present: load it to outputs, stay HOLD (1/cycle).
    - Ack in the same cycle: forward `imem_rdata` directly, stay HOLD.
    - Request still pending: go FETCH; the address is unchanged, so the handshake remains stable.
  - On accept with `next_pc != pc+1`:
    - Buffer full: discard it, go FETCH.
    - Request pending: go DRAIN.
    - Mismatch coinciding with ack: discard, go FETCH.
- Undefined: no prefetch buffer and no DRAIN state; base behaviour only.

## Structure
- `fetch_pkg`: state enum {BOOT, FETCH, HOLD, DRAIN}, `PC_W`/`INSTR_W` defaults, `RESET_PC` default.
- One sub-module: `fetch_prefetch_buf` (one-entry buffer plus pending/valid flags), instantiated only under `FETCH_PREFETCH_EN`.

## Test plan
- Reset: hold `rst_n`=0, drive `imem_ack`=1 → all outputs at reset values, `imem_req`=0. Release → `imem_req`=1 with addr 12'h000 one cycle later.
- Sequential, zero-wait, `id_ready`=1, `next_pc`=`pc+1` → addresses 000,001,002 fetched. Base: `if_valid` pulses every 2 cycles. Prefetch: every cycle after the first.
- Jump: accept while `next_pc`=12'h222 → next `imem_addr`=12'h222, `if_pc`=12'h222. Prefetch on with a pending request → DRAIN completes the stale 12'h001 read, which never reaches `if_instr`.
- 3-cycle-wait memory plus `id_ready` low for 4 cycles → `imem_addr` stable until ack; `if_instr`/`if_pc` stable through the stall; no instruction lost or duplicated.
- Wrap: RESET_PC=12'hFFE, sequential → addresses FFE, FFF, 000.
- Reset asserted mid-request (req high, no ack) → `imem_req` drops immediately; after release, fetch restarts at RESET_PC.
